// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch-request controller sitting in front of the PC+4 adder.
// Picks the next PC from npc, branch/jump/trap redirects or a buffered redirect.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      npc,
  output logic [31:0]      pc,
  output logic             if_req_valid,
  input  logic             if_req_ready,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jmp_en,
  input  logic [31:0]      jmp_target,
  input  logic             trap_en,
  input  logic [31:0]      trap_target,
  output logic             redirect_pending,
  output logic             pc_misalign,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {StBoot, StReq, StStall} state_e;

  state_e             state_q;
  logic [31:0]        pc_q;
  logic [31:0]        pend_tgt_q;
  logic               pending_q;
  logic               valid_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               redir;
  logic [31:0]        redir_tgt;

  // Trap beats jump beats branch.
  always_comb begin
    redir     = trap_en | jmp_en | br_taken;
    redir_tgt = br_target;
    if (trap_en) begin
      redir_tgt = trap_target;
    end else if (jmp_en) begin
      redir_tgt = jmp_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      pending_q  <= 1'b0;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        StBoot: begin
          if (redir) begin
            pc_q <= redir_tgt;
          end
          state_q <= stall ? StStall : StReq;
          valid_q <= ~stall;
        end
        StReq: begin
          if (if_req_ready) begin
            // A same-cycle redirect wins over the buffered one.
            pc_q      <= redir ? redir_tgt : (pending_q ? pend_tgt_q : npc);
            pending_q <= 1'b0;
            cnt_q     <= cnt_q + CNT_W'(1);
            state_q   <= stall ? StStall : StReq;
            valid_q   <= ~stall;
          end else if (redir) begin
            // Request is outstanding and must stay stable; park the redirect.
            pend_tgt_q <= redir_tgt;
            pending_q  <= 1'b1;
          end
        end
        StStall: begin
          if (redir) begin
            pc_q      <= redir_tgt;
            pending_q <= 1'b0;
          end else if (pending_q) begin
            pc_q      <= pend_tgt_q;
            pending_q <= 1'b0;
          end
          if (!stall) begin
            state_q <= StReq;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StBoot;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc               = pc_q;
  assign if_req_valid     = valid_q;
  assign redirect_pending = pending_q;
  assign pc_misalign      = |pc_q[1:0];
  assign fetch_cnt        = cnt_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the architectural PC register directly upstream of the PC+4 adder.
- Drives `pc` to the adder and to the instruction-memory fetch port.
- Selects the next PC among the sequential `npc` returned by the adder, branch/jump targets and the trap vector.
- Issues fetch requests under a valid/ready handshake, honours pipeline stalls, and buffers a redirect that arrives while a fetch is still pending.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 32, width of the accepted-fetch counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- npc  in  32  sequential next PC from the PC+4 adder (pc+4).
- pc  out  32  current PC; feeds the adder and the fetch address.
- if_req_valid  out  1  fetch request for address `pc`.
- if_req_ready  in  1  instruction memory accepts the request.
- stall  in  1  downstream cannot take a new instruction.
- br_taken  in  1  branch redirect.
- br_target  in  32  branch target.
- jmp_en  in  1  jump redirect.
- jmp_target  in  32  jump target.
- trap_en  in  1  exception/trap redirect.
- trap_target  in  32  trap vector.
- redirect_pending  out  1  a buffered redirect is waiting.
- pc_misalign  out  1  pc[1:0] != 2'b00.
- fetch_cnt  out  CNT_W  count of accepted fetches.

Behaviour:
- Reset (synchronous, rst=1 at edge), takes effect regardless of state or in-flight request:
  - pc=RESET_PC, state=BOOT, if_req_valid=0.
  - Pending register cleared, redirect_pending=0, fetch_cnt=0, pc_misalign=0.
- Redirect priority: trap_en > jmp_en > br_taken. `redir` is the OR of the three; `redir_tgt` is the winning target.
- States:
  - BOOT:
    - if_req_valid=0.
    - Next cycle goes to REQ, or to STALL if stall=1.
    - A redirect in BOOT is written to pc directly.
  - REQ:
    - if_req_valid=1, address=pc.
    - Handshake (valid & ready):
      - pc <= redir ? redir_tgt : (pending ? pend_tgt : npc).
      - A same-cycle redirect beats the buffered one.
      - Pending cleared; fetch_cnt++ (wraps at 2^CNT_W).
      - Next state STALL if stall=1, else REQ.
    - No handshake:
      - pc and if_req_valid held stable; the request must not change while outstanding.
      - If redir, pend_tgt <= redir_tgt and pending=1; a later redirect overwrites an earlier one.
      - stall is ignored until acceptance.
  - STALL:
    - if_req_valid=0, pc held.
    - redir: pc <= redir_tgt and pending cleared next edge.
    - Leaves to REQ the cycle after stall=0.
    - If pending=1 on entry, pc <= pend_tgt in the first STALL cycle and pending is cleared.
- Latency:
  - Accepted fetch → new pc visible the next cycle.
  - Redirect with handshake → target visible the next cycle and issued in that cycle's REQ.
- pc_misalign is combinational from pc. The block still fetches a misaligned pc; the exception decision belongs downstream.
- npc is used as-is; no internal +4.
- redirect_pending mirrors the pending flag.

Test Plan:
- Reset then ready=1, stall=0 for 4 cycles → pc sequence 3000,3004,3008,300C; fetch_cnt=3 after third handshake; valid=0 during BOOT.
- pc=3008, ready=0 for 3 cycles with br_taken=1 (target 3100) in the 2nd cycle → pc stays 3008, valid=1 stable, redirect_pending=1; on ready=1 the next pc=3100, pending=0.
- Same cycle as handshake at pc=3010: br_taken=1 (target 3200) and trap_en=1 (target 4180) → next pc=4180.
- stall=1 at handshake of pc=3004 → valid=0 and pc=3008 held while stall is high; jmp_en=1 (target 3400) during the stall → pc=3400; stall=0 → REQ issues 3400.
- jmp_target=3402 → pc=3402, pc_misalign=1, request still issued.
- rst=1 mid-REQ with ready=0 and pending=1 → next cycle pc=3000, valid=0, pending=0, fetch_cnt=0.
